// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the sequential ALU: opcode encodings, the control
// FSM state type and small opcode classification helpers.
//
// Opcodes keep the ainv/binv/op layout of the original ripple ALU:
//   opcode[3] = ainv, opcode[2] = binv, opcode[1:0] = base operation.
// MULU and the shifts occupy the otherwise unused ainv=1/binv=0 encodings.

package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } aluStateT;

    // Operations that go through the shared adder and report cout/overflow.
    function automatic logic isArith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Operations that subtract: the adder sees ~b with a carry-in of 1.
    function automatic logic isSubtract(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic isLegal(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR) ||
               (op == OP_MULU) || (op == OP_SLL) || (op == OP_SRL) ||
               (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, discards any partial product
//   start_i    load operands; the first iteration is performed on this edge
//   mcand_i    multiplicand (WIDTH bits)
//   mplier_i   multiplier (WIDTH bits)
//   busy_o     an operation is in progress
//   done_o     the final iteration happens at the coming edge
//   product_o  2*WIDTH product; valid while done_o is high
//
// The product register holds {partial high half, remaining multiplier bits}.
// Each iteration conditionally adds the multiplicand to the high half and
// shifts the whole register right by one, so after WIDTH iterations it holds
// the full product. Because the first iteration runs on the start edge, the
// last one runs when the counter steps to WIDTH-1, i.e. WIDTH-1 cycles later.

module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] hiQ;
    logic [WIDTH-1:0] loQ;
    logic [WIDTH-1:0] mcandQ;
    logic [CNT_W-1:0] cntQ;
    logic             busyQ;

    logic             load;
    logic [WIDTH-1:0] stepHiIn;
    logic [WIDTH-1:0] stepLoIn;
    logic [WIDTH-1:0] stepMcand;
    logic [WIDTH:0]   stepSum;
    logic [WIDTH-1:0] hiD;
    logic [WIDTH-1:0] loD;

    assign load = start_i && !busyQ;

    // One shift-add step. On a load the step works on the fresh operands
    // (empty high half), otherwise on the registered partial product.
    always_comb begin
        if (load) begin
            stepHiIn  = '0;
            stepLoIn  = mplier_i;
            stepMcand = mcand_i;
        end else begin
            stepHiIn  = hiQ;
            stepLoIn  = loQ;
            stepMcand = mcandQ;
        end
        stepSum = {1'b0, stepHiIn} +
                  (stepLoIn[0] ? {1'b0, stepMcand} : {(WIDTH+1){1'b0}});
        hiD = stepSum[WIDTH:1];
        loD = {stepSum[0], stepLoIn[WIDTH-1:1]};
    end

    assign busy_o    = busyQ;
    assign done_o    = busyQ && (cntQ == CNT_W'(WIDTH - 2));
    assign product_o = {hiD, loD};

    // Iteration state: partial product, multiplicand copy and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hiQ    <= '0;
            loQ    <= '0;
            mcandQ <= '0;
            cntQ   <= '0;
            busyQ  <= 1'b0;
        end else if (load) begin
            hiQ    <= hiD;
            loQ    <= loD;
            mcandQ <= mcand_i;
            cntQ   <= '0;
            busyQ  <= 1'b1;
        end else if (busyQ) begin
            hiQ  <= hiD;
            loQ  <= loD;
            cntQ <= cntQ + 1'b1;
            if (done_o) begin
                busyQ <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Handshaked, single-outstanding-operation ALU. Logic ops, add/sub/slt and
// shifts complete in one cycle; MULU runs on the iterative multiplier and
// returns a double-width product. All outputs are registered.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operation handshake (in_ready high only in IDLE)
//   a, b, opcode          operands and operation, sampled at accept
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   result                result, or low half of the product
//   result_hi             high half of the product, 0 for other ops
//   cout, overflow        adder carry out of the MSB / signed overflow
//   zero                  result (both halves for MULU) is zero
//   illegal               opcode is reserved

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    aluStateT         stateQ;
    logic             inReadyQ;
    logic             outValidQ;
    logic [WIDTH-1:0] resultQ;
    logic [WIDTH-1:0] resultHiQ;
    logic             coutQ;
    logic             overflowQ;
    logic             zeroQ;
    logic             illegalQ;

    logic [WIDTH-1:0] aInv;
    logic [WIDTH-1:0] bInv;
    logic [WIDTH:0]   addSum;
    logic             carryIntoMsb;
    logic             addOvf;
    logic [SHAMT_W-1:0] shamt;

    logic [WIDTH-1:0] aluResultD;
    logic             aluCoutD;
    logic             aluOvfD;
    logic             aluIllegalD;

    logic               mulStart;
    logic               mulBusy;
    logic               mulDone;
    logic [2*WIDTH-1:0] mulProduct;

    // Operand inversion from the ainv/binv opcode bits; AND with both
    // inverted gives NOR, and binv with a carry-in of 1 gives subtraction.
    assign aInv  = opcode[3] ? ~a : a;
    assign bInv  = opcode[2] ? ~b : b;
    assign shamt = b[SHAMT_W-1:0];

    // Shared adder. Overflow is the carry into the MSB XOR the carry out,
    // recovering the MSB carry-in from the sum bit and its two inputs.
    assign addSum       = {1'b0, a} + {1'b0, bInv} + (WIDTH+1)'(isSubtract(opcode));
    assign carryIntoMsb = a[WIDTH-1] ^ bInv[WIDTH-1] ^ addSum[WIDTH-1];
    assign addOvf       = carryIntoMsb ^ addSum[WIDTH];

    // Single-cycle result computed straight from the offered operands, so it
    // can be registered on the accept edge. SLT uses sign XOR overflow so the
    // comparison stays correct when a-b overflows.
    always_comb begin
        aluResultD  = '0;
        aluCoutD    = 1'b0;
        aluOvfD     = 1'b0;
        aluIllegalD = !isLegal(opcode);
        case (opcode)
            OP_AND, OP_NOR: aluResultD = aInv & bInv;
            OP_OR:          aluResultD = aInv | bInv;
            OP_ADD, OP_SUB: aluResultD = addSum[WIDTH-1:0];
            OP_SLT:         aluResultD = {{(WIDTH-1){1'b0}}, addSum[WIDTH-1] ^ addOvf};
            OP_SLL:         aluResultD = a << shamt;
            OP_SRL:         aluResultD = a >> shamt;
            OP_SRA:         aluResultD = WIDTH'($signed(a) >>> shamt);
            default:        aluResultD = '0;
        endcase
        if (isArith(opcode)) begin
            aluCoutD = addSum[WIDTH];
            aluOvfD  = addOvf;
        end
    end

    assign mulStart = (stateQ == IDLE) && in_valid && (opcode == OP_MULU);

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) uMul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mulStart),
        .mcand_i   (a),
        .mplier_i  (b),
        .busy_o    (mulBusy),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    // Control FSM with all handshake and result outputs registered. in_ready
    // depends only on the state transition, never on out_ready directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            resultQ   <= '0;
            resultHiQ <= '0;
            coutQ     <= 1'b0;
            overflowQ <= 1'b0;
            zeroQ     <= 1'b0;
            illegalQ  <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (in_valid) begin
                        inReadyQ <= 1'b0;
                        if (opcode == OP_MULU) begin
                            stateQ <= MUL;
                        end else begin
                            stateQ    <= DONE;
                            outValidQ <= 1'b1;
                            resultQ   <= aluResultD;
                            resultHiQ <= '0;
                            coutQ     <= aluCoutD;
                            overflowQ <= aluOvfD;
                            zeroQ     <= (aluResultD == '0);
                            illegalQ  <= aluIllegalD;
                        end
                    end
                end
                MUL: begin
                    if (mulBusy && mulDone) begin
                        stateQ    <= DONE;
                        outValidQ <= 1'b1;
                        resultQ   <= mulProduct[WIDTH-1:0];
                        resultHiQ <= mulProduct[2*WIDTH-1:WIDTH];
                        coutQ     <= 1'b0;
                        overflowQ <= 1'b0;
                        zeroQ     <= (mulProduct == '0);
                        illegalQ  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        stateQ    <= IDLE;
                        outValidQ <= 1'b0;
                        inReadyQ  <= 1'b1;
                    end
                end
                default: begin
                    stateQ    <= IDLE;
                    outValidQ <= 1'b0;
                    inReadyQ  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = outValidQ;
    assign result    = resultQ;
    assign result_hi = resultHiQ;
    assign cout      = coutQ;
    assign overflow  = overflowQ;
    assign zero      = zeroQ;
    assign illegal   = illegalQ;

endmodule
